// File: rtl/bridge_utils.sv
// Shared encodings for the AXI-to-APB bridge scheduler: handler command/status,
// AXI burst types and the scheduler state enum.
package bridge_utils;

  typedef enum logic [1:0] {
    CmdNone    = 2'd0,
    CmdGetAddr = 2'd1,
    CmdXfer    = 2'd2,
    CmdResp    = 2'd3
  } cmd_e;

  typedef enum logic [1:0] {
    InfoIdle = 2'd0,
    InfoBusy = 2'd1,
    InfoBeat = 2'd2,
    InfoDone = 2'd3
  } info_e;

  typedef enum logic [1:0] {
    BurstFixed = 2'd0,
    BurstIncr  = 2'd1,
    BurstWrap  = 2'd2,
    BurstRsvd  = 2'd3
  } burst_e;

  typedef enum logic [2:0] {
    StIdle,
    StGetAddr,
    StWaitBeat,
    StApb,
    StResp
  } state_e;

  // Largest beat size the APB side can carry: 4 bytes.
  localparam int unsigned MaxSize = 2;

endpackage

// File: rtl/bridge_addr_gen.sv
// Combinational next-beat address for FIXED/INCR/WRAP bursts, plus the
// legality check that decides whether a burst may touch APB at all.
module bridge_addr_gen
  import bridge_utils::*;
#(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [3:0]            len,
  input  logic [2:0]            size,
  input  logic [1:0]            burst,
  output logic [ADDR_WIDTH-1:0] next_addr,
  output logic                  illegal
);

  logic [ADDR_WIDTH-1:0] step;
  logic [ADDR_WIDTH-1:0] incr;
  logic [ADDR_WIDTH-1:0] bsz;
  logic [ADDR_WIDTH-1:0] mask;
  logic                  wrap_len_ok;

  always_comb begin
    step        = ADDR_WIDTH'(1) << size;
    incr        = addr + step;
    bsz         = (ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size;
    mask        = bsz - ADDR_WIDTH'(1);
    wrap_len_ok = (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
    illegal     = (size > 3'(MaxSize)) || (burst == BurstRsvd) ||
                  ((burst == BurstWrap) && !wrap_len_ok);
    case (burst)
      BurstIncr: next_addr = incr;
      BurstWrap: next_addr = (addr & ~mask) | (incr & mask);
      default:   next_addr = addr;
    endcase
  end

endmodule

// File: rtl/bridge_scheduler.sv
// Round-robin scheduler that turns AXI read/write handler requests into one APB
// access per beat, tracking burst address, beat count and the error response.
module bridge_scheduler
  import bridge_utils::*;
#(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ar_pending,
  input  logic                  aw_pending,
  output logic [1:0]            rd_cmd,
  output logic [1:0]            wr_cmd,
  input  logic [1:0]            rd_info,
  input  logic [1:0]            wr_info,
  input  logic                  addr_valid,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [3:0]            len,
  input  logic [2:0]            size,
  input  logic [1:0]            burst,
  output logic                  apb_req,
  output logic                  apb_write,
  output logic [ADDR_WIDTH-1:0] apb_addr,
  input  logic                  apb_done,
  input  logic                  apb_err,
  output logic                  beat_ack,
  output logic                  beat_last,
  output logic                  resp_err,
  output logic                  sel_write,
  output logic                  busy
);

  state_e                state_q, state_d;
  logic                  sel_write_q, sel_write_d;
  logic                  last_write_q, last_write_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [3:0]            len_q, len_d;
  logic [2:0]            size_q, size_d;
  logic [1:0]            burst_q, burst_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  err_q, err_d;

  logic [ADDR_WIDTH-1:0] next_addr;
  logic                  illegal;
  logic [1:0]            info_sel;
  logic                  beat_done;
  cmd_e                  cmd;

  bridge_addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_addr_gen (
    .addr     (addr_q),
    .len      (len_q),
    .size     (size_q),
    .burst    (burst_q),
    .next_addr(next_addr),
    .illegal  (illegal)
  );

  assign info_sel = sel_write_q ? wr_info : rd_info;

  always_comb begin
    state_d      = state_q;
    sel_write_d  = sel_write_q;
    last_write_d = last_write_q;
    addr_d       = addr_q;
    len_d        = len_q;
    size_d       = size_q;
    burst_d      = burst_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    cmd          = CmdNone;
    beat_done    = 1'b0;
    beat_ack     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (ar_pending || aw_pending) begin
          sel_write_d = aw_pending && (!ar_pending || !last_write_q);
          state_d     = StGetAddr;
        end
      end
      StGetAddr: begin
        cmd = CmdGetAddr;
        if (addr_valid) begin
          addr_d  = addr;
          len_d   = len;
          size_d  = size;
          burst_d = burst;
          cnt_d   = 4'd0;
          err_d   = 1'b0;
          state_d = StWaitBeat;
        end
      end
      StWaitBeat: begin
        cmd = CmdXfer;
        if (info_sel == InfoBeat) begin
          // Illegal bursts are drained beat by beat without touching APB.
          if (illegal) beat_done = 1'b1;
          else         state_d   = StApb;
        end
      end
      StApb: begin
        cmd = CmdXfer;
        if (apb_done) begin
          beat_done = 1'b1;
          err_d     = err_q | apb_err;
        end
      end
      StResp: begin
        cmd = CmdResp;
        if (info_sel == InfoDone) begin
          last_write_d = sel_write_q;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (beat_done) begin
      beat_ack = 1'b1;
      if (cnt_q == len_q) begin
        state_d = StResp;
      end else begin
        cnt_d   = cnt_q + 4'd1;
        addr_d  = next_addr;
        state_d = StWaitBeat;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      sel_write_q  <= 1'b0;
      last_write_q <= 1'b1;
      addr_q       <= '0;
      len_q        <= 4'd0;
      size_q       <= 3'd0;
      burst_q      <= 2'd0;
      cnt_q        <= 4'd0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_write_q  <= sel_write_d;
      last_write_q <= last_write_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      size_q       <= size_d;
      burst_q      <= burst_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
    end
  end

  assign busy      = (state_q != StIdle);
  assign rd_cmd    = sel_write_q ? CmdNone : cmd;
  assign wr_cmd    = sel_write_q ? cmd : CmdNone;
  assign apb_req   = (state_q == StApb);
  assign apb_write = apb_req & sel_write_q;
  assign apb_addr  = addr_q;
  assign beat_last = busy && (cnt_q == len_q);
  assign resp_err  = err_q | illegal;
  assign sel_write = sel_write_q;

endmodule

// File: tb/tb_bridge_scheduler.sv
// Directed bench for bridge_scheduler: emulates both AXI handlers and the APB
// slave, and checks every cycle against a burst-level address/response model.
module tb_bridge_scheduler;

  localparam int unsigned AW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ar_pending = 1'b0;
  logic          aw_pending = 1'b0;
  logic [1:0]    rd_cmd, wr_cmd;
  logic [1:0]    rd_info = 2'd0;
  logic [1:0]    wr_info = 2'd0;
  logic          addr_valid = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [3:0]    len = 4'd0;
  logic [2:0]    size = 3'd0;
  logic [1:0]    burst = 2'd0;
  logic          apb_req, apb_write;
  logic [AW-1:0] apb_addr;
  logic          apb_done = 1'b0;
  logic          apb_err = 1'b0;
  logic          beat_ack, beat_last, resp_err, sel_write, busy;

  bridge_scheduler #(
    .ADDR_WIDTH(AW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ar_pending(ar_pending),
    .aw_pending(aw_pending),
    .rd_cmd    (rd_cmd),
    .wr_cmd    (wr_cmd),
    .rd_info   (rd_info),
    .wr_info   (wr_info),
    .addr_valid(addr_valid),
    .addr      (addr),
    .len       (len),
    .size      (size),
    .burst     (burst),
    .apb_req   (apb_req),
    .apb_write (apb_write),
    .apb_addr  (apb_addr),
    .apb_done  (apb_done),
    .apb_err   (apb_err),
    .beat_ack  (beat_ack),
    .beat_last (beat_last),
    .resp_err  (resp_err),
    .sel_write (sel_write),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Expectation for the burst currently in flight.
  logic        exp_write;
  logic [31:0] exp_base;
  logic [3:0]  exp_len;
  logic [2:0]  exp_size;
  logic [1:0]  exp_burst;
  logic        exp_legal;
  logic        exp_err;

  // Observations gathered by the compare process.
  int          beat_idx = 0;
  int          acks = 0;
  logic [31:0] obs[$];
  logic        seen_resp_err = 1'b0;
  logic [31:0] want[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  function automatic logic [31:0] model_addr(input logic [31:0] a, input int l, input int s,
                                             input int b, input int i);
    logic [31:0] stp, bsz, base;
    stp = 32'(1) << s;
    case (b)
      1: return a + 32'(i) * stp;
      2: begin
        bsz  = 32'(l + 1) * stp;
        base = a - (a % bsz);
        return base + ((a - base + 32'(i) * stp) % bsz);
      end
      default: return a;
    endcase
  endfunction

  function automatic bit model_illegal(input int l, input int s, input int b);
    return (s > 2) || (b == 3) || ((b == 2) && !(l == 1 || l == 3 || l == 7 || l == 15));
  endfunction

  // Per-cycle compare against the burst model.
  logic [1:0] gcmd, ocmd;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        gcmd = sel_write ? wr_cmd : rd_cmd;
        ocmd = sel_write ? rd_cmd : wr_cmd;
        if (!busy) check("idle_cmds", 64'({rd_cmd, wr_cmd}), 64'(0));
        else       check("other_cmd", 64'(ocmd), 64'(0));
        if (busy && gcmd == 2'd1) begin
          check("grant_side", 64'(sel_write), 64'(exp_write));
          beat_idx = 0;
          acks     = 0;
          obs.delete();
        end
        if (apb_req) begin
          check("apb_allowed", 64'(1), 64'(exp_legal));
          check("apb_addr", 64'(apb_addr),
                64'(model_addr(exp_base, int'(exp_len), int'(exp_size), int'(exp_burst),
                               beat_idx)));
          check("apb_write", 64'(apb_write), 64'(exp_write));
        end
        if (beat_ack) begin
          check("beat_last", 64'(beat_last), 64'(beat_idx == int'(exp_len)));
          check("ack_via_apb", 64'(apb_req), 64'(exp_legal));
          if (apb_req) obs.push_back(apb_addr);
          beat_idx++;
          acks++;
        end
        if (busy && gcmd == 2'd3) begin
          check("resp_err", 64'(resp_err), 64'(exp_err));
          check("beat_count", 64'(beat_idx), 64'(int'(exp_len) + 1));
          seen_resp_err = resp_err;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cmd(input bit w, input logic [1:0] code);
    int n = 0;
    while (((w ? wr_cmd : rd_cmd) != code) && n < 60) begin
      step();
      n++;
    end
    check(w ? "wr_cmd_wait" : "rd_cmd_wait", 64'(w ? wr_cmd : rd_cmd), 64'(code));
  endtask

  task automatic set_info(input bit w, input logic [1:0] v);
    if (w) wr_info = v;
    else   rd_info = v;
  endtask

  task automatic check_reset_outputs(input string nm);
    check(nm, 64'({rd_cmd, wr_cmd, apb_req, apb_write, beat_ack, beat_last, resp_err,
                   sel_write, busy}), 64'(0));
    check({nm, "_addr"}, 64'(apb_addr), 64'(0));
  endtask

  task automatic txn(input bit w, input logic [31:0] a, input logic [3:0] l,
                     input logic [2:0] s, input logic [1:0] b, input logic [15:0] emask,
                     input int abort_beat);
    exp_write = w;
    exp_base  = a;
    exp_len   = l;
    exp_size  = s;
    exp_burst = b;
    exp_legal = !model_illegal(int'(l), int'(s), int'(b));
    exp_err   = !exp_legal;
    for (int i = 0; i <= int'(l); i++) if (exp_legal && emask[i]) exp_err = 1'b1;
    if (w) aw_pending = 1'b1;
    else   ar_pending = 1'b1;
    wait_cmd(w, 2'd1);
    if (w) aw_pending = 1'b0;
    else   ar_pending = 1'b0;
    addr_valid = 1'b1;
    addr = a;
    len = l;
    size = s;
    burst = b;
    step();
    addr_valid = 1'b0;
    for (int i = 0; i <= int'(l); i++) begin
      wait_cmd(w, 2'd2);
      set_info(w, 2'd2);
      step();
      set_info(w, 2'd1);
      if (exp_legal) begin
        if (i == abort_beat) begin
          rst = 1'b1;
          step();
          check_reset_outputs("abort_outputs");
          set_info(w, 2'd0);
          rst = 1'b0;
          return;
        end
        step();
        apb_done = 1'b1;
        apb_err  = emask[i];
        step();
        apb_done = 1'b0;
        apb_err  = 1'b0;
      end
    end
    wait_cmd(w, 2'd3);
    step();
    set_info(w, 2'd3);
    step();
    set_info(w, 2'd0);
  endtask

  task automatic check_obs(input string nm);
    check({nm, "_count"}, 64'(obs.size()), 64'(want.size()));
    for (int i = 0; i < want.size(); i++)
      if (i < obs.size()) check(nm, 64'(obs[i]), 64'(want[i]));
  endtask

  initial begin
    repeat (3) step();
    check_reset_outputs("reset_outputs");
    ar_pending = 1'b1;
    aw_pending = 1'b1;
    rst = 1'b0;

    // Contention from reset: read first, then write.
    txn(1'b0, 32'h1000, 4'd0, 3'd2, 2'd1, 16'h0, -1);
    want = {32'h1000};
    check_obs("single_read");
    check("single_read_resp", 64'(seen_resp_err), 64'(0));
    check("single_read_acks", 64'(acks), 64'(1));

    txn(1'b1, 32'h2000, 4'd3, 3'd2, 2'd1, 16'h0, -1);
    want = {32'h2000, 32'h2004, 32'h2008, 32'h200C};
    check_obs("incr_write");
    check("incr_write_acks", 64'(acks), 64'(4));

    txn(1'b0, 32'h3008, 4'd3, 3'd2, 2'd2, 16'h0, -1);
    want = {32'h3008, 32'h300C, 32'h3000, 32'h3004};
    check_obs("wrap_read");

    txn(1'b1, 32'h7000, 4'd1, 3'd3, 2'd1, 16'h0, -1);
    want = {};
    check_obs("bad_size");
    check("bad_size_acks", 64'(acks), 64'(2));
    check("bad_size_resp", 64'(seen_resp_err), 64'(1));

    txn(1'b0, 32'h7100, 4'd1, 3'd2, 2'd1, 16'h2, -1);
    check("apb_err_resp", 64'(seen_resp_err), 64'(1));

    txn(1'b0, 32'hFFFF_FFFC, 4'd1, 3'd2, 2'd1, 16'h0, -1);
    want = {32'hFFFF_FFFC, 32'h0000_0000};
    check_obs("addr_wrap_top");

    txn(1'b1, 32'h4005, 4'd15, 3'd0, 2'd2, 16'h0, -1);
    check("wrap16_acks", 64'(acks), 64'(16));
    if (obs.size() == 16) begin
      check("wrap16_b10", 64'(obs[10]), 64'(32'h400F));
      check("wrap16_b11", 64'(obs[11]), 64'(32'h4000));
      check("wrap16_b15", 64'(obs[15]), 64'(32'h4004));
    end else begin
      check("wrap16_count", 64'(obs.size()), 64'(16));
    end

    txn(1'b0, 32'h7200, 4'd0, 3'd2, 2'd3, 16'h0, -1);
    check("rsvd_burst_resp", 64'(seen_resp_err), 64'(1));

    txn(1'b1, 32'h7300, 4'd2, 3'd2, 2'd2, 16'h0, -1);
    check("bad_wrap_len_resp", 64'(seen_resp_err), 64'(1));
    check("bad_wrap_len_apb", 64'(obs.size()), 64'(0));

    // Stray apb_done while idle must be ignored.
    apb_done = 1'b1;
    #3;
    check("stray_done_ack", 64'(beat_ack), 64'(0));
    step();
    apb_done = 1'b0;
    check("stray_done_busy", 64'(busy), 64'(0));

    txn(1'b1, 32'h5000, 4'd3, 3'd2, 2'd1, 16'h0, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("post_abort_quiet", 64'({apb_req, busy}), 64'(0));
    end

    txn(1'b0, 32'h6002, 4'd2, 3'd1, 2'd0, 16'h0, -1);
    want = {32'h6002, 32'h6002, 32'h6002};
    check_obs("fixed_after_abort");
    check("fixed_after_abort_resp", 64'(seen_resp_err), 64'(0));

    repeat (2) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
